bitfusion_seq_ctrl: RTL and testbench

Job sequencer for the ARRAY_SIZE x ARRAY_SIZE bit-fusion systolic array. It accepts a job configuration and a streamed load of weight and input words. It steers those words into the per-PE weight buffers and per-row input buffers, then issues the skewed read enables that march data through the array. It clears and drains the column accumulators and flags when the output buffer holds valid sums. It sits between the host/DMA stream and the array top level; it drives every array write enable, read enable, clear, sign and bitwidth control.

---
 rtl/bitfusion_seq_ctrl_if.sv | 11 +
 rtl/bitfusion_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_bitfusion_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitfusion_seq_ctrl_if.sv
// Load stream into the bit-fusion sequencer: host/DMA is master, sequencer is slave.
interface bitfusion_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/bitfusion_seq_ctrl.sv
// Job sequencer for the bit-fusion systolic array: steers the load stream into the
// weight/input buffers, then drives the skewed read enables, accumulator clear and done flags.
module bitfusion_seq_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int BUF_DEPTH  = 16,
  parameter int PIPE_LAT   = 3
) (
  input  logic                                clk,
  input  logic                                nRST,
  input  logic                                start,
  input  logic                                abort,
  input  logic [$clog2(BUF_DEPTH):0]          cfg_k_len,
  input  logic [2:0]                          cfg_in_bw,
  input  logic [2:0]                          cfg_w_bw,
  input  logic                                cfg_in_signed,
  input  logic                                cfg_w_signed,
  bitfusion_seq_ctrl_if.slave                 ld,
  output logic [DATA_W-1:0]                   data_in,
  output logic [ARRAY_SIZE-1:0]               IBUF_wr_en,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]    WBUF_wr_en,
  output logic [ARRAY_SIZE-1:0]               input_rd_en,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]    weight_rd_en,
  output logic [ARRAY_SIZE-1:0]               acc_clear,
  output logic [ARRAY_SIZE*ARRAY_SIZE*4-1:0]  input_sign,
  output logic [ARRAY_SIZE*ARRAY_SIZE*4-1:0]  weight_sign,
  output logic [2:0]                          input_bitwidth,
  output logic [2:0]                          weight_bitwidth,
  output logic                                busy,
  output logic                                done,
  output logic                                obuf_valid,
  output logic                                cfg_err
);

  localparam int NPE    = ARRAY_SIZE * ARRAY_SIZE;
  localparam int K_W    = $clog2(BUF_DEPTH) + 1;
  localparam int SLOT_W = $clog2(NPE);
  localparam int T_W    = $clog2(BUF_DEPTH + 2 * ARRAY_SIZE + PIPE_LAT) + 1;

  // state     | meaning
  // S_IDLE    | waiting for a legal start
  // S_LOAD_W  | accepting A*A*K weight words
  // S_LOAD_I  | accepting A*K input words
  // S_CLEAR   | one-cycle accumulator clear
  // S_COMPUTE | skewed reads, t = 0 .. K+2(A-1)-1
  // S_DRAIN   | PIPE_LAT cycles for the last sum to reach OBUF
  // S_DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_I, S_CLEAR, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;
  logic [K_W-1:0]    step, step_nxt;
  logic [T_W-1:0]    t, t_nxt;

  logic [K_W-1:0]    k_len_q;
  logic [2:0]        in_bw_q, w_bw_q;
  logic              in_sg_q, w_sg_q;

  logic              cfg_ok, hs, start_ok, start_bad;
  logic              last_step;
  logic [T_W-1:0]    t_last;
  logic [ARRAY_SIZE-1:0] in_rd_nxt;
  logic [NPE-1:0]        w_rd_nxt;

  assign cfg_ok = (cfg_k_len != '0) && (cfg_k_len <= K_W'(BUF_DEPTH))
                  && !cfg_in_bw[2] && !cfg_w_bw[2];

  assign ld.ld_ready = ((state == S_LOAD_W) || (state == S_LOAD_I)) && !abort;
  assign hs          = ld.ld_valid && ld.ld_ready;
  assign last_step   = (step == k_len_q - K_W'(1));
  assign t_last      = T_W'(k_len_q) + T_W'(2 * ARRAY_SIZE - 3);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      slot  <= '0;
      step  <= '0;
      t     <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      step  <= step_nxt;
      t     <= t_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    step_nxt  = step;
    t_nxt     = t;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
      slot_nxt  = '0;
      step_nxt  = '0;
      t_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              start_ok  = 1'b1;
              state_nxt = S_LOAD_W;
              slot_nxt  = '0;
              step_nxt  = '0;
            end else begin
              start_bad = 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (hs) begin
            if (slot == SLOT_W'(NPE - 1)) begin
              slot_nxt = '0;
              if (last_step) begin
                step_nxt  = '0;
                state_nxt = S_LOAD_I;
              end else begin
                step_nxt = step + K_W'(1);
              end
            end else begin
              slot_nxt = slot + SLOT_W'(1);
            end
          end
        end
        S_LOAD_I: begin
          if (hs) begin
            if (slot == SLOT_W'(ARRAY_SIZE - 1)) begin
              slot_nxt = '0;
              if (last_step) begin
                step_nxt  = '0;
                state_nxt = S_CLEAR;
              end else begin
                step_nxt = step + K_W'(1);
              end
            end else begin
              slot_nxt = slot + SLOT_W'(1);
            end
          end
        end
        S_CLEAR: begin
          state_nxt = S_COMPUTE;
          t_nxt     = '0;
        end
        S_COMPUTE: begin
          if (t == t_last) begin
            state_nxt = S_DRAIN;
            t_nxt     = '0;
          end else begin
            t_nxt = t + T_W'(1);
          end
        end
        S_DRAIN: begin
          if (t == T_W'(PIPE_LAT - 1)) begin
            state_nxt = S_DONE;
            t_nxt     = '0;
          end else begin
            t_nxt = t + T_W'(1);
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Read enables are registered, so they are computed from the next state/count.
  always_comb begin
    in_rd_nxt = '0;
    w_rd_nxt  = '0;
    if (state_nxt == S_COMPUTE) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        in_rd_nxt[i] = (int'(t_nxt) >= i) && (int'(t_nxt) < i + int'(k_len_q));
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          w_rd_nxt[i*ARRAY_SIZE+j] = (int'(t_nxt) >= i + j)
                                     && (int'(t_nxt) < i + j + int'(k_len_q));
        end
      end
    end
  end

  always_comb begin
    IBUF_wr_en = '0;
    WBUF_wr_en = '0;
    for (int r = 0; r < ARRAY_SIZE; r++) begin
      IBUF_wr_en[r] = (state == S_LOAD_I) && hs && (slot == SLOT_W'(r));
    end
    for (int p = 0; p < NPE; p++) begin
      WBUF_wr_en[p] = (state == S_LOAD_W) && hs && (slot == SLOT_W'(p));
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      input_rd_en  <= '0;
      weight_rd_en <= '0;
      k_len_q      <= '0;
      in_bw_q      <= '0;
      w_bw_q       <= '0;
      in_sg_q      <= 1'b0;
      w_sg_q       <= 1'b0;
      obuf_valid   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      input_rd_en  <= in_rd_nxt;
      weight_rd_en <= w_rd_nxt;
      if (start_ok) begin
        k_len_q <= cfg_k_len;
        in_bw_q <= cfg_in_bw;
        w_bw_q  <= cfg_w_bw;
        in_sg_q <= cfg_in_signed;
        w_sg_q  <= cfg_w_signed;
      end
      if (abort || start_ok) begin
        obuf_valid <= 1'b0;
      end else if (state_nxt == S_DONE) begin
        obuf_valid <= 1'b1;
      end
      if (start_ok) begin
        cfg_err <= 1'b0;
      end else if (start_bad) begin
        cfg_err <= 1'b1;
      end
    end
  end

  assign data_in         = ld.ld_data;
  assign acc_clear       = {ARRAY_SIZE{state == S_CLEAR}};
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign input_bitwidth  = in_bw_q;
  assign weight_bitwidth = w_bw_q;
  assign input_sign      = {(NPE*4){in_sg_q}};
  assign weight_sign     = {(NPE*4){w_sg_q}};

endmodule

// File: tb/tb_bitfusion_seq_ctrl.sv
// Scoreboard bench for bitfusion_seq_ctrl: the driver pushes expected buffer writes and
// per-cycle array control derived from the job rules; a negedge monitor pops and compares.
module tb_bitfusion_seq_ctrl;
  localparam int A   = 4;
  localparam int DW  = 32;
  localparam int BD  = 16;
  localparam int PL  = 3;
  localparam int KW  = 5;
  localparam int NPE = A * A;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0;
  logic [KW-1:0] cfg_k_len = '0;
  logic [2:0]    cfg_in_bw = '0, cfg_w_bw = '0;
  logic          cfg_in_signed = 1'b0, cfg_w_signed = 1'b0;
  logic [DW-1:0] data_in;
  logic [A-1:0]  IBUF_wr_en, input_rd_en, acc_clear;
  logic [NPE-1:0] WBUF_wr_en, weight_rd_en;
  logic [NPE*4-1:0] input_sign, weight_sign;
  logic [2:0]    input_bitwidth, weight_bitwidth;
  logic          busy, done, obuf_valid, cfg_err;

  bitfusion_seq_ctrl_if #(.DATA_W(DW)) ld_if ();

  bitfusion_seq_ctrl #(.ARRAY_SIZE(A), .DATA_W(DW), .BUF_DEPTH(BD), .PIPE_LAT(PL)) dut (
    .clk(clk), .nRST(nRST), .start(start), .abort(abort),
    .cfg_k_len(cfg_k_len), .cfg_in_bw(cfg_in_bw), .cfg_w_bw(cfg_w_bw),
    .cfg_in_signed(cfg_in_signed), .cfg_w_signed(cfg_w_signed),
    .ld(ld_if), .data_in(data_in),
    .IBUF_wr_en(IBUF_wr_en), .WBUF_wr_en(WBUF_wr_en),
    .input_rd_en(input_rd_en), .weight_rd_en(weight_rd_en), .acc_clear(acc_clear),
    .input_sign(input_sign), .weight_sign(weight_sign),
    .input_bitwidth(input_bitwidth), .weight_bitwidth(weight_bitwidth),
    .busy(busy), .done(done), .obuf_valid(obuf_valid), .cfg_err(cfg_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic          is_w;
    int            idx;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [A-1:0]   clr;
    logic [A-1:0]   ird;
    logic [NPE-1:0] wrd;
    logic           dn;
    logic           ov;
    logic           bsy;
  } cyc_t;

  wr_t  wr_q[$];
  cyc_t cyc_q[$];
  bit   cyc_on = 1'b0;
  logic [2:0] m_ibw = '0, m_wbw = '0;
  logic       m_is = 1'b0, m_ws = 1'b0;

  function automatic cyc_t mk(logic [A-1:0] clr, logic [A-1:0] ird, logic [NPE-1:0] wrd,
                              logic dn, logic ov, logic bsy);
    cyc_t c;
    c.clr = clr; c.ird = ird; c.wrd = wrd; c.dn = dn; c.ov = ov; c.bsy = bsy;
    return c;
  endfunction

  // Reference: data step s reaches row i at cycle s+i and PE(i,j) at cycle s+i+j after COMPUTE starts.
  task automatic push_job(int k, logic [2:0] ibw, logic [2:0] wbw, logic is, logic ws);
    int c;
    logic [A-1:0]   ird;
    logic [NPE-1:0] wrd;
    c = k + 2 * (A - 1);
    m_ibw = ibw; m_wbw = wbw; m_is = is; m_ws = ws;
    cyc_q.push_back(mk('1, '0, '0, 1'b0, 1'b0, 1'b1));
    for (int tt = 0; tt < c; tt++) begin
      ird = '0;
      wrd = '0;
      for (int s = 0; s < k; s++) begin
        for (int i = 0; i < A; i++) begin
          if (s + i == tt) ird = ird | (A'(1) << i);
          for (int j = 0; j < A; j++)
            if (s + i + j == tt) wrd = wrd | (NPE'(1) << (i * A + j));
        end
      end
      cyc_q.push_back(mk('0, ird, wrd, 1'b0, 1'b0, 1'b1));
    end
    for (int p = 0; p < PL; p++) cyc_q.push_back(mk('0, '0, '0, 1'b0, 1'b0, 1'b1));
    cyc_q.push_back(mk('0, '0, '0, 1'b1, 1'b1, 1'b1));
    cyc_q.push_back(mk('0, '0, '0, 1'b0, 1'b1, 1'b0));
  endtask

  always @(negedge clk) begin
    if (nRST) begin
      if (WBUF_wr_en != '0 || IBUF_wr_en != '0) begin
        wr_t e;
        logic [NPE-1:0] ew;
        logic [A-1:0]   ei;
        if (wr_q.size() == 0) begin
          check("unexpected_write", 64'({WBUF_wr_en, IBUF_wr_en}), 64'(0));
        end else begin
          e  = wr_q.pop_front();
          ew = e.is_w ? (NPE'(1) << e.idx) : '0;
          ei = e.is_w ? '0 : (A'(1) << e.idx);
          check("wbuf_wr_en", 64'(WBUF_wr_en), 64'(ew));
          check("ibuf_wr_en", 64'(IBUF_wr_en), 64'(ei));
          check("data_in", 64'(data_in), 64'(e.data));
        end
      end
      if (cyc_q.size() != 0 && (cyc_on || acc_clear != '0)) begin
        cyc_t c;
        c = cyc_q.pop_front();
        cyc_on = (cyc_q.size() != 0);
        check("acc_clear", 64'(acc_clear), 64'(c.clr));
        check("input_rd_en", 64'(input_rd_en), 64'(c.ird));
        check("weight_rd_en", 64'(weight_rd_en), 64'(c.wrd));
        check("done", 64'(done), 64'(c.dn));
        check("obuf_valid", 64'(obuf_valid), 64'(c.ov));
        check("busy", 64'(busy), 64'(c.bsy));
        check("input_bitwidth", 64'(input_bitwidth), 64'(m_ibw));
        check("weight_bitwidth", 64'(weight_bitwidth), 64'(m_wbw));
        check("input_sign", input_sign, {64{m_is}});
        check("weight_sign", weight_sign, {64{m_ws}});
      end else if (acc_clear != '0 || input_rd_en != '0 || weight_rd_en != '0 || done) begin
        check("unexpected_array_ctrl", 64'({done, acc_clear, input_rd_en, weight_rd_en}), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(int k, int ibw, int wbw, logic is, logic ws);
    cfg_k_len = KW'(k); cfg_in_bw = 3'(ibw); cfg_w_bw = 3'(wbw);
    cfg_in_signed = is; cfg_w_signed = ws;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams words; stops before word index stop_at (leaving it unsent) when stop_at >= 0.
  task automatic stream(bit is_w, int count, bit gap, int stop_at);
    for (int n = 0; n < count; n++) begin
      wr_t e;
      if (n == stop_at) return;
      if (gap) begin
        ld_if.ld_valid = 1'b0;
        tick();
      end
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = $urandom;
      e.is_w = is_w;
      e.idx  = is_w ? (((n / A) % A) * A + (n % A)) : (n % A);
      e.data = ld_if.ld_data;
      wr_q.push_back(e);
      tick();
    end
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("done_within_budget", 64'(done), 64'(1));
  endtask

  task automatic run_job(int k, int ibw, int wbw, logic is, logic ws, bit gap, bit start_mid);
    push_job(k, 3'(ibw), 3'(wbw), is, ws);
    issue_start(k, ibw, wbw, is, ws);
    check("cfg_err_cleared", 64'(cfg_err), 64'(0));
    check("ld_ready_in_load", 64'(ld_if.ld_ready), 64'(1));
    stream(1'b1, NPE * k, gap, -1);
    stream(1'b0, A * k, gap, -1);
    check("ld_ready_after_load", 64'(ld_if.ld_ready), 64'(0));
    if (start_mid) begin
      tick();
      tick();
      issue_start(1, ibw ^ 1, wbw ^ 2, !is, !ws);
    end
    wait_done();
    tick();
    check("obuf_valid_holds", 64'(obuf_valid), 64'(1));
    check("busy_idle_after_done", 64'(busy), 64'(0));
    tick();
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ld_ready", 64'(ld_if.ld_ready), 64'(0));
    check("rst_wbuf", 64'(WBUF_wr_en), 64'(0));
    check("rst_rd_en", 64'({input_rd_en, weight_rd_en, acc_clear}), 64'(0));
    check("rst_flags", 64'({done, obuf_valid, cfg_err}), 64'(0));
    check("rst_cfg", 64'({input_bitwidth, weight_bitwidth, input_sign[0], weight_sign[0]}), 64'(0));
    #20;
    nRST = 1'b1;
    tick();

    issue_start(0, 3, 3, 1'b0, 1'b0);
    check("cfg_err_k0", 64'(cfg_err), 64'(1));
    check("busy_k0", 64'(busy), 64'(0));
    check("ld_ready_k0", 64'(ld_if.ld_ready), 64'(0));
    issue_start(4, 0, 5, 1'b0, 1'b0);
    check("cfg_err_wbw5", 64'(cfg_err), 64'(1));
    check("busy_wbw5", 64'(busy), 64'(0));
    issue_start(17, 0, 0, 1'b0, 1'b0);
    check("cfg_err_k17", 64'(cfg_err), 64'(1));
    check("busy_k17", 64'(busy), 64'(0));

    run_job(1, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(4, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_job(2, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_job(BD, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // abort during LOAD_I after 3 input words, with ld_valid still high
    push_job(3, 3'd2, 3'd2, 1'b0, 1'b0);
    issue_start(3, 2, 2, 1'b0, 1'b0);
    stream(1'b1, NPE * 3, 1'b0, -1);
    stream(1'b0, A * 3, 1'b0, 3);
    cyc_q.delete();
    cyc_on = 1'b0;
    ld_if.ld_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ld_ready", 64'(ld_if.ld_ready), 64'(0));
    check("abort_obuf_valid", 64'(obuf_valid), 64'(0));
    tick();
    tick();
    ld_if.ld_valid = 1'b0;
    run_job(2, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // start and abort together in IDLE: abort wins, nothing changes except obuf_valid drop
    cfg_k_len = KW'(2); cfg_in_bw = 3'd0; cfg_w_bw = 3'd0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'(0));
    check("start_abort_ld_ready", 64'(ld_if.ld_ready), 64'(0));
    check("start_abort_obuf", 64'(obuf_valid), 64'(0));
    check("start_abort_cfg_err", 64'(cfg_err), 64'(0));
    check("start_abort_bw_held", 64'({input_bitwidth, weight_bitwidth}), 64'({3'd1, 3'd1}));
    tick();
    check("start_abort_busy_later", 64'(busy), 64'(0));

    // async reset at COMPUTE t=3
    push_job(2, 3'd3, 3'd0, 1'b1, 1'b1);
    issue_start(2, 3, 0, 1'b1, 1'b1);
    stream(1'b1, NPE * 2, 1'b0, -1);
    stream(1'b0, A * 2, 1'b0, -1);
    for (int i = 0; i < 4; i++) tick();
    check("t3_input_rd_en", 64'(input_rd_en), 64'(4'b1100));
    cyc_q.delete();
    cyc_on = 1'b0;
    nRST = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_rd_en", 64'({input_rd_en, weight_rd_en, acc_clear}), 64'(0));
    check("rstmid_flags", 64'({done, obuf_valid, cfg_err, ld_if.ld_ready}), 64'(0));
    check("rstmid_cfg", 64'({input_bitwidth, weight_bitwidth, input_sign[0]}), 64'(0));
    tick();
    nRST = 1'b1;
    tick();
    run_job(3, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      run_job(int'($urandom_range(1, BD)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    tick();
    check("wr_q_drained", 64'(wr_q.size()), 64'(0));
    check("cyc_q_drained", 64'(cyc_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
